// File: rtl/tinker_mem_pkg.sv
// Shared types for the Tinker memory unit: FSM states, channel ids and access-size codes.
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    CH_IF = 1'b0,
    CH_D  = 1'b1
  } chan_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/tinker_mem_byte_array.sv
// Synchronous byte RAM: LANES consecutive bytes starting at addr_i are read or written per cycle.
module tinker_mem_byte_array #(
  parameter int MEM_BYTES = 524288,
  parameter int LANES     = 8,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic               clk,
  input  logic [AW-1:0]      addr_i,
  input  logic               rd_en_i,
  input  logic [LANES-1:0]   wr_en_i,
  input  logic [LANES*8-1:0] wdata_i,
  output logic [LANES*8-1:0] rdata_o
);

  logic [7:0]    mem_q     [MEM_BYTES];
  logic [AW-1:0] lane_addr [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = addr_i + AW'(i);
    end
  end

  // NOTE: storage and its read register are deliberately not reset, so contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en_i[i]) mem_q[lane_addr[i]] <= wdata_i[8*i +: 8];
      if (rd_en_i)    rdata_o[8*i +: 8]  <= mem_q[lane_addr[i]];
    end
  end

endmodule

// File: rtl/tinker_mem_unit.sv
// Multi-cycle byte-addressed memory serving a fetch channel and a data channel,
// with configurable latency, sized little-endian accesses and range/alignment errors.
module tinker_mem_unit
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 524288,
  parameter int DATA_W    = 64,
  parameter int INSTR_W   = 32,
  parameter int LATENCY   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_ack,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_err,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [1:0]         d_size,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_ack,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_err,
  output logic               busy
);

  localparam int DLANES = DATA_W / 8;
  localparam int LANES  = (DLANES > 4) ? DLANES : 4;
  localparam int AW     = $clog2(MEM_BYTES);
  localparam int CNT_W  = $clog2(LATENCY + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  chan_e              ch_q;
  logic               we_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               err_q;

  chan_e              cur_ch;
  logic               cur_we;
  logic [1:0]         cur_size;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  cur_wdata;
  logic [3:0]         cur_nbytes;
  logic [ADDR_W:0]    cur_end;
  logic               cur_err;
  logic               any_req;
  logic               enter_resp;

  logic               ram_rd_en;
  logic [LANES-1:0]   ram_wr_en;
  logic [LANES*8-1:0] ram_wdata;
  logic [LANES*8-1:0] ram_rdata;

  assign any_req = if_req | d_req;

  // In IDLE the access is described by the live request (needed when LATENCY=1 commits
  // on the accept edge itself); afterwards by the fields latched at accept.
  always_comb begin
    cur_ch    = ch_q;
    cur_we    = we_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_ch    = d_req ? CH_D : CH_IF;
      cur_we    = d_req & d_we;
      cur_size  = d_req ? d_size : SZ_W;
      cur_addr  = d_req ? d_addr : if_addr;
      cur_wdata = d_wdata;
    end
  end

  always_comb begin
    cur_nbytes = size_to_bytes(cur_size);
    cur_end    = {1'b0, cur_addr} + (ADDR_W+1)'(cur_nbytes) - (ADDR_W+1)'(1);
    cur_err    = (cur_end >= (ADDR_W+1)'(MEM_BYTES))
               | ((cur_ch == CH_IF) && (cur_addr[1:0] != 2'b00))
               | ((cur_ch == CH_D) && (int'(cur_nbytes) > DLANES));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset on the edge that would enter RESP aborts the access, so the RAM stays untouched.
  assign enter_resp = (state_d == RESP) && !reset;
  assign ram_rd_en  = enter_resp && !cur_we && !cur_err;
  assign ram_wdata  = (LANES*8)'(cur_wdata);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ram_wr_en[i] = enter_resp && cur_we && !cur_err && (i < int'(cur_nbytes));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= CH_IF;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && any_req) begin
        ch_q    <= cur_ch;
        we_q    <= cur_we;
        size_q  <= cur_size;
        addr_q  <= cur_addr;
        wdata_q <= cur_wdata;
      end
      if (state_d == RESP) err_q <= cur_err;
    end
  end

  tinker_mem_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .LANES     (LANES),
    .AW        (AW)
  ) u_array (
    .clk     (clk),
    .addr_i  (cur_addr[AW-1:0]),
    .rd_en_i (ram_rd_en),
    .wr_en_i (ram_wr_en),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign busy   = (state_q != IDLE);
  assign d_ack  = (state_q == RESP) && (ch_q == CH_D);
  assign if_ack = (state_q == RESP) && (ch_q == CH_IF);
  assign d_err  = d_ack & err_q;
  assign if_err = if_ack & err_q;

  always_comb begin
    d_rdata = '0;
    if (d_ack && !err_q && !we_q) begin
      for (int i = 0; i < DLANES; i++) begin
        if (i < int'(size_to_bytes(size_q))) d_rdata[8*i +: 8] = ram_rdata[8*i +: 8];
      end
    end
  end

  assign if_instr = (if_ack && !err_q) ? ram_rdata[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_tinker_mem_unit.sv
// Bench for tinker_mem_unit: LATENCY=1 unit checked against a byte-level reference model,
// plus LATENCY=2 (throughput) and LATENCY=3 (reset abort) instances.
module tb_tinker_mem_unit;

  localparam int MEMB = 524288;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int checks   = 0;
  int failures = 0;

  // LATENCY=1 instance
  logic        if_req, if_ack, if_err;
  logic [63:0] if_addr;
  logic [31:0] if_instr;
  logic        d_req, d_we, d_ack, d_err, busy;
  logic [1:0]  d_size;
  logic [63:0] d_addr, d_wdata, d_rdata;

  // LATENCY=2 instance (data channel only)
  logic        b_d_req, b_d_we, b_d_ack, b_d_err, b_busy, b_if_ack, b_if_err;
  logic [1:0]  b_d_size;
  logic [63:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_if_instr;

  // LATENCY=3 instance (data channel only)
  logic        c_d_req, c_d_we, c_d_ack, c_d_err, c_busy, c_if_ack, c_if_err;
  logic [1:0]  c_d_size;
  logic [63:0] c_d_addr, c_d_wdata, c_d_rdata;
  logic [31:0] c_if_instr;

  tinker_mem_unit #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .busy(busy)
  );

  tinker_mem_unit #(.LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(64'd0), .if_ack(b_if_ack), .if_instr(b_if_instr), .if_err(b_if_err),
    .d_req(b_d_req), .d_we(b_d_we), .d_size(b_d_size), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_err(b_d_err), .busy(b_busy)
  );

  tinker_mem_unit #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(64'd0), .if_ack(c_if_ack), .if_instr(c_if_instr), .if_err(c_if_err),
    .d_req(c_d_req), .d_we(c_d_we), .d_size(c_d_size), .d_addr(c_d_addr), .d_wdata(c_d_wdata),
    .d_ack(c_d_ack), .d_rdata(c_d_rdata), .d_err(c_d_err), .busy(c_busy)
  );

  // Reference model: contents of every byte the bench has successfully stored.
  logic [7:0] mem_m [longint unsigned];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Data access on the LATENCY=1 unit; returns cycles from accept to ack (0 = timed out).
  task automatic d_op(input logic we, input logic [1:0] size, input logic [63:0] addr,
                      input logic [63:0] wdata, output logic [63:0] rdata, output logic err,
                      output int lat);
    d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    lat = 0; rdata = '0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_ack) begin
        lat = k; rdata = d_rdata; err = d_err;
        break;
      end
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic if_op(input logic [63:0] addr, output logic [63:0] instr, output logic err,
                       output int lat);
    if_addr = addr; if_req = 1'b1;
    lat = 0; instr = '0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if_ack) begin
        lat = k; instr = 64'(if_instr); err = if_err;
        break;
      end
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_read(input logic [63:0] addr, input int n, output logic [63:0] val,
                            output bit known);
    val = '0; known = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (mem_m.exists(addr + 64'(i))) val = val | (64'(mem_m[addr + 64'(i)]) << (8 * i));
      else known = 1'b0;
    end
  endtask

  task automatic d_check(input string tag, input logic we, input logic [1:0] size,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata);
    int          n, lat;
    logic        exp_err, err;
    logic [63:0] exp_rd;
    bit          known;
    n       = 1 << size;
    exp_err = ({1'b0, addr} + 65'(n)) > 65'(MEMB);
    exp_rd  = '0;
    known   = 1'b1;
    if (!exp_err && !we) model_read(addr, n, exp_rd, known);
    d_op(we, size, addr, wdata, rdata, err, lat);
    check({tag, " latency"}, 64'(lat), 64'd1);
    check({tag, " d_err"}, 64'(err), 64'(exp_err));
    if (!we && (exp_err || known)) check({tag, " d_rdata"}, rdata, exp_rd);
    if (we && !exp_err) begin
      for (int i = 0; i < n; i++) mem_m[addr + 64'(i)] = wdata[8*i +: 8];
    end
  endtask

  task automatic if_check(input string tag, input logic [63:0] addr, output logic [63:0] instr);
    int          lat;
    logic        exp_err, err;
    logic [63:0] exp_in;
    bit          known;
    exp_err = (addr[1:0] != 2'b00) || (({1'b0, addr} + 65'd4) > 65'(MEMB));
    exp_in  = '0;
    known   = 1'b1;
    if (!exp_err) model_read(addr, 4, exp_in, known);
    if_op(addr, instr, err, lat);
    check({tag, " latency"}, 64'(lat), 64'd1);
    check({tag, " if_err"}, 64'(err), 64'(exp_err));
    if (exp_err || known) check({tag, " if_instr"}, instr, exp_in);
  endtask

  initial begin
    logic [63:0] rd, w;
    logic        e;
    int          lat, t_d, t_i, n, acks_seen;
    int          ack_t [$];
    logic [1:0]  sz;
    logic [63:0] a;

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_size = '0; b_d_addr = '0; b_d_wdata = '0;
    c_d_req = 1'b0; c_d_we = 1'b0; c_d_size = '0; c_d_addr = '0; c_d_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst if_ack", 64'(if_ack), 64'd0);
    check("rst if_err", 64'(if_err), 64'd0);
    check("rst if_instr", 64'(if_instr), 64'd0);
    check("rst d_ack", 64'(d_ack), 64'd0);
    check("rst d_err", 64'(d_err), 64'd0);
    check("rst d_rdata", d_rdata, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst busy L2", 64'(b_busy), 64'd0);
    check("rst busy L3", 64'(c_busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch of a preloaded little-endian word
    d_check("preload 0x2000", 1'b1, 2'd2, 64'h2000, 64'h12345678, rd);
    if_check("fetch 0x2000", 64'h2000, rd);
    check("fetch 0x2000 value", rd, 64'h12345678);

    // Sized store then narrower load
    d_check("store D @0x1000", 1'b1, 2'd3, 64'h1000, 64'h1122334455667788, rd);
    d_check("load H @0x1002", 1'b0, 2'd1, 64'h1002, 64'd0, rd);
    check("load H @0x1002 value", rd, 64'h5566);

    // Arbitration: both channels requested in the same IDLE cycle
    if_addr = 64'h2000; if_req = 1'b1;
    d_we = 1'b0; d_size = 2'd2; d_addr = 64'h1000; d_req = 1'b1;
    t_d = 0; t_i = 0; w = '0; rd = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!d_ack) check("arb d_err without ack", 64'(d_err), 64'd0);
      if (d_ack) begin t_d = k; rd = d_rdata; d_req = 1'b0; end
      if (if_ack) begin t_i = k; w = 64'(if_instr); if_req = 1'b0; break; end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("arb d_ack cycle", 64'(t_d), 64'd1);
    check("arb if_ack cycle", 64'(t_i), 64'd3);
    check("arb d_rdata", rd, 64'h55667788);
    check("arb if_instr", w, 64'h12345678);

    // Error cases
    d_check("load D @top-4", 1'b0, 2'd3, 64'(MEMB - 4), 64'd0, rd);
    check("load D @top-4 rdata zero", rd, 64'd0);
    d_check("store B @top-1", 1'b1, 2'd0, 64'(MEMB - 1), 64'hA5, rd);
    d_check("store H @top-1", 1'b1, 2'd1, 64'(MEMB - 1), 64'hBEEF, rd);
    d_check("reload B @top-1", 1'b0, 2'd0, 64'(MEMB - 1), 64'd0, rd);
    check("top-1 unchanged", rd, 64'hA5);
    if_check("fetch 0x2002", 64'h2002, rd);
    check("fetch 0x2002 instr zero", rd, 64'd0);
    if_check("fetch top-2", 64'(MEMB - 2), rd);

    // Randomized traffic against the reference model
    for (int a0 = 'h3000; a0 < 'h3100; a0 += 8) begin
      w = {$urandom, $urandom};
      d_check("init region", 1'b1, 2'd3, 64'(a0), w, rd);
    end
    for (int it = 0; it < 60; it++) begin
      sz = 2'($urandom_range(0, 3));
      n  = 1 << sz;
      w  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        5: d_check("rand top", 1'($urandom_range(0, 1)), sz, 64'(MEMB - int'($urandom_range(1, 8))), w, rd);
        4: if_check("rand fetch", 64'('h3000 + $urandom_range(0, 'hFC)), rd);
        default: begin
          a = 64'('h3000 + $urandom_range(0, 256 - n));
          d_check("rand data", 1'($urandom_range(0, 1)), sz, a, w, rd);
        end
      endcase
    end

    // LATENCY=3: reset during WAIT aborts a store
    c_d_we = 1'b1; c_d_size = 2'd3; c_d_addr = 64'h4000; c_d_wdata = 64'hCAFEF00D_DEADBEEF;
    c_d_req = 1'b1; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (c_d_ack) begin lat = k; break; end
    end
    c_d_req = 1'b0;
    @(negedge clk);
    check("L3 preload latency", 64'(lat), 64'd3);
    c_d_wdata = 64'h0123456789ABCDEF; c_d_req = 1'b1;
    @(negedge clk);
    check("L3 accepted busy", 64'(c_busy), 64'd1);
    reset = 1'b1; c_d_req = 1'b0;
    @(negedge clk);
    check("L3 busy after reset", 64'(c_busy), 64'd0);
    check("L3 no ack at reset", 64'(c_d_ack), 64'd0);
    reset = 1'b0;
    acks_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (c_d_ack) acks_seen++;
    end
    check("L3 no ack after abort", 64'(acks_seen), 64'd0);
    c_d_we = 1'b0; c_d_req = 1'b1; lat = 0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (c_d_ack) begin lat = k; rd = c_d_rdata; break; end
    end
    c_d_req = 1'b0;
    @(negedge clk);
    check("L3 load latency", 64'(lat), 64'd3);
    check("L3 bytes unchanged", rd, 64'hCAFEF00D_DEADBEEF);

    // LATENCY=2: held request gives three accesses spaced LATENCY+1 cycles apart
    b_d_we = 1'b1; b_d_size = 2'd3; b_d_addr = 64'h5000; b_d_wdata = 64'h0F1E2D3C4B5A6978;
    b_d_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k <= 8) check($sformatf("L2 busy cycle %0d", k), 64'(b_busy), 64'((k % 3) != 0));
      if (b_d_ack) begin
        ack_t.push_back(k);
        if (ack_t.size() == 3) break;
      end
    end
    b_d_req = 1'b0;
    @(negedge clk);
    check("L2 ack count", 64'(ack_t.size()), 64'd3);
    if (ack_t.size() == 3) begin
      check("L2 first ack", 64'(ack_t[0]), 64'd2);
      check("L2 spacing 1", 64'(ack_t[1] - ack_t[0]), 64'd3);
      check("L2 spacing 2", 64'(ack_t[2] - ack_t[1]), 64'd3);
    end
    b_d_we = 1'b0; b_d_req = 1'b1; lat = 0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b_d_ack) begin lat = k; rd = b_d_rdata; break; end
    end
    b_d_req = 1'b0;
    @(negedge clk);
    check("L2 load latency", 64'(lat), 64'd2);
    check("L2 stored data", rd, 64'h0F1E2D3C4B5A6978);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
